data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_pkg.sv | 13 +
 rtl/data_mem_ctrl_dmem_array.sv | 33 +++
 rtl/data_mem_ctrl.sv | 87 ++++++++
 tb/tb_data_mem_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared widths and FSM encoding for the unified instruction/data memory controller.
package data_mem_ctrl_pkg;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 256;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// 256x16 storage: one write port, a free-running fetch read port and an enabled data read port.
module dmem_array
    import data_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic              re_b_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // Contents survive reset; only the read registers are cleared.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Reads sample the pre-write word, so a same-edge write shows up one fetch later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_a_o <= '0;
        else      rdata_a_o <= mem_q[raddr_a_i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rdata_b_o <= '0;
        else if (re_b_i) rdata_b_o <= mem_q[raddr_b_i];
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Memory controller: fixed-latency load/store handshake plus a 1-cycle instruction fetch port.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int LATENCY = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] memAddrLoadStore,
    input  logic [DATA_W-1:0] memStoreVal,
    input  logic              readReq,
    input  logic              writeReq,
    output logic [DATA_W-1:0] memLoadVal,
    output logic              valueReady,
    input  logic              powerdown,
    output logic              idle
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              finish;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Write wins a read/write tie; the held readReq is picked up on the next IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!powerdown && (writeReq || readReq)) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_INIT;
                    wr_d    = writeReq;
                    addr_d  = memAddrLoadStore;
                    if (writeReq) data_d = memStoreVal;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign finish     = (state_q == ST_BUSY) && (cnt_q == '0);
    assign valueReady = (state_q == ST_DONE);
    assign idle       = (state_q == ST_IDLE);

    dmem_array u_array (
        .clk       (clk),
        .rst       (rst),
        .we_i      (finish && wr_q),
        .waddr_i   (addr_q),
        .wdata_i   (data_q),
        .raddr_a_i (instr_addr),
        .rdata_a_o (instr),
        .re_b_i    (finish && !wr_q),
        .raddr_b_i (addr_q),
        .rdata_b_o (memLoadVal)
    );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl with a transaction-timing reference model.
module tb_data_mem_ctrl;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  instr_addr = '0;
    logic [15:0] instr;
    logic [7:0]  memAddrLoadStore = '0;
    logic [15:0] memStoreVal = '0;
    logic        readReq = 1'b0;
    logic        writeReq = 1'b0;
    logic [15:0] memLoadVal;
    logic        valueReady;
    logic        powerdown = 1'b0;
    logic        idle;

    int total = 0;
    int bad = 0;
    bit rand_iaddr = 1'b0;

    data_mem_ctrl #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr),
        .memAddrLoadStore(memAddrLoadStore), .memStoreVal(memStoreVal),
        .readReq(readReq), .writeReq(writeReq), .memLoadVal(memLoadVal),
        .valueReady(valueReady), .powerdown(powerdown), .idle(idle)
    );

    always #5 clk = ~clk;

    // Reference model: a transaction accepted at edge S commits at S+LAT,
    // pulses valueReady in the following cycle and frees the port at S+LAT+1.
    int          cyc = 0;
    int          t_start = 0;
    bit          act = 1'b0;
    bit          t_wr;
    logic [7:0]  t_addr;
    logic [15:0] t_data;
    logic [15:0] mmem [256];
    bit          mvalid [256];
    logic [15:0] exp_instr = '0;
    logic [15:0] exp_load = '0;
    bit          exp_instr_ok = 1'b0;
    bit          exp_load_ok = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            act = 1'b0;
            exp_load = '0;     exp_load_ok = 1'b1;
            exp_instr = '0;    exp_instr_ok = 1'b1;
        end else begin
            cyc++;
            exp_instr    = mmem[instr_addr];
            exp_instr_ok = mvalid[instr_addr];
            if (act && cyc == t_start + LAT) begin
                if (t_wr) begin
                    mmem[t_addr] = t_data;
                    mvalid[t_addr] = 1'b1;
                end else begin
                    exp_load    = mmem[t_addr];
                    exp_load_ok = mvalid[t_addr];
                end
            end
            if (act && cyc == t_start + LAT + 1) act = 1'b0;
            else if (!act && !powerdown && (readReq || writeReq)) begin
                act = 1'b1;  t_start = cyc;  t_wr = writeReq;
                t_addr = memAddrLoadStore;  t_data = memStoreVal;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("idle", idle, !act);
            check("valueReady", valueReady, act && cyc == t_start + LAT);
            if (exp_instr_ok) check("instr", instr, exp_instr);
            if (exp_load_ok)  check("memLoadVal", memLoadVal, exp_load);
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_iaddr) instr_addr = 8'($urandom);
    endtask

    task automatic wait_vr(input bit noise, output int n, output bit got);
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (valueReady) begin
                got = 1'b1;
                return;
            end
            if (noise) begin
                memAddrLoadStore = 8'($urandom);
                memStoreVal      = 16'($urandom);
                powerdown        = 1'($urandom);
            end
        end
        total++;
        bad++;
        $display("FAIL vr_timeout: no valueReady within 40 cycles (t=%0t)", $time);
    endtask

    // Requester: holds the request(s) until valueReady, dropping the write after the first pulse.
    task automatic txn(input bit wr, input bit rd, input logic [7:0] a, input logic [15:0] d,
                       input int stall, input bit noise,
                       output int n1, output int n2, output logic [15:0] ld, output logic [15:0] iv);
        bit got;
        memAddrLoadStore = a;  memStoreVal = d;
        writeReq = wr;  readReq = rd;
        powerdown = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("pd_no_ready", valueReady, 1'b0);
            check("pd_idle", idle, 1'b1);
        end
        powerdown = 1'b0;
        n2 = 0;
        wait_vr(noise && !(wr && rd), n1, got);
        iv = instr;
        ld = memLoadVal;
        if (wr && rd && got) begin
            writeReq = 1'b0;
            wait_vr(1'b0, n2, got);
            ld = memLoadVal;
        end
        writeReq = 1'b0;  readReq = 1'b0;  powerdown = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n1, n2, op;
        logic [15:0] ld, iv;
        logic [7:0] a;

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_idle", idle, 1'b1);
        check("rst_vr", valueReady, 1'b0);
        check("rst_load", memLoadVal, 16'h0);
        check("rst_instr", instr, 16'h0);
        #2 rst = 1'b1;
        tick();

        txn(1, 0, 8'h0A, 16'h1357, 0, 0, n1, n2, ld, iv);
        txn(1, 0, 8'h10, 16'h5555, 0, 0, n1, n2, ld, iv);

        // Write 0x0A<-BEEF while fetching 0x0A: old word at the commit edge, new word after.
        instr_addr = 8'h0A;
        txn(1, 0, 8'h0A, 16'hBEEF, 0, 0, n1, n2, ld, iv);
        check("wr_latency", n1, LAT + 1);
        check("wr_keeps_load", ld, 16'h0000);
        check("instr_old_word", iv, 16'h1357);
        check("instr_new_word", instr, 16'hBEEF);

        txn(0, 1, 8'h0A, 16'h0, 0, 0, n1, n2, ld, iv);
        check("rd_latency", n1, LAT + 1);
        check("rd_value", ld, 16'hBEEF);
        repeat (3) tick();
        check("rd_hold", memLoadVal, 16'hBEEF);

        txn(1, 1, 8'h11, 16'h1234, 0, 0, n1, n2, ld, iv);
        check("both_first", n1, LAT + 1);
        check("both_second", n2, LAT + 2);
        check("both_read", ld, 16'h1234);

        txn(0, 1, 8'h10, 16'h0, 10, 0, n1, n2, ld, iv);
        check("pd_release_latency", n1, LAT + 1);
        check("pd_read", ld, 16'h5555);

        // Reset mid-write must drop the store entirely.
        memAddrLoadStore = 8'h10;  memStoreVal = 16'hAAAA;  writeReq = 1'b1;
        tick();
        check("abort_busy", idle, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("abort_idle", idle, 1'b1);
        check("abort_vr", valueReady, 1'b0);
        check("abort_load", memLoadVal, 16'h0);
        check("abort_instr", instr, 16'h0);
        writeReq = 1'b0;
        tick();
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_vr", valueReady, 1'b0);
        end
        txn(0, 1, 8'h10, 16'h0, 0, 0, n1, n2, ld, iv);
        check("abort_kept_old", ld, 16'h5555);

        rand_iaddr = 1'b1;
        for (int k = 0; k < 150; k++) begin
            op = int'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            txn(op != 0, op != 1, a, 16'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                1'($urandom), n1, n2, ld, iv);
            check("rand_latency", n1, LAT + 1);
            if (op == 2) check("rand_latency2", n2, LAT + 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
